pipe_stage_chain: RTL and testbench

- Parametrised successor to the single-stage ID/EX pipeline latch.
- DEPTH back-to-back pipeline registers carry a valid bit, a CTRL_W-bit control bundle, a DATA_W-bit data bundle and a PC.
- Supports freeze (hold every stage), bubble (insert a NOP at the chain head while downstream advances) and flush (kill every stage).
- Intended to replace the hand-written ID/EX, EX/MEM and MEM/WB latches in the pipelined CPU.

---
 rtl/pipe_stage_chain.sv | 136 +++++++++++++
 tb/tb_pipe_stage_chain.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH back-to-back pipeline registers carrying valid,
// control, data and PC, with freeze (stall), head bubble and full flush.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_chain #(
    parameter int          DEPTH       = 1,
    parameter int          CTRL_W      = 16,
    parameter int          DATA_W      = 128,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter logic [31:0] PC_RST      = 32'h80000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [31:0]                in_pc,
    input  logic                       stall,
    input  logic                       bubble,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [DATA_W-1:0]          out_data,
    output logic [31:0]                out_pc,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]                perf_stall_cnt,
    output logic [31:0]                perf_bubble_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              v_q [DEPTH];
    logic [CTRL_W-1:0] c_q [DEPTH];
    logic [DATA_W-1:0] d_q [DEPTH];
    logic [31:0]       p_q [DEPTH];
    logic [OCC_W-1:0]  occ_q;

    logic              v_n [DEPTH];
    logic [CTRL_W-1:0] c_n [DEPTH];
    logic [DATA_W-1:0] d_n [DEPTH];
    logic [31:0]       p_n [DEPTH];
    logic [OCC_W-1:0]  occ_n;

    // Next-state of every stage: flush kills but still shifts d/p, stall holds,
    // otherwise shift with stage 0 taking either the input or a NOP.
    always_comb begin
        // NOTE: hold is the default for every stage so no path leaves a
        // register unassigned and no latch is inferred.
        for (int k = 0; k < DEPTH; k++) begin
            v_n[k] = v_q[k];
            c_n[k] = c_q[k];
            d_n[k] = d_q[k];
            p_n[k] = p_q[k];
        end
        if (flush || !stall) begin
            for (int k = 1; k < DEPTH; k++) begin
                v_n[k] = v_q[k-1];
                c_n[k] = c_q[k-1];
                d_n[k] = d_q[k-1];
                p_n[k] = p_q[k-1];
            end
            v_n[0] = in_valid && !bubble;
            c_n[0] = (in_valid && !bubble) ? in_ctrl : CTRL_BUBBLE;
            d_n[0] = in_data;
            p_n[0] = in_pc;
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) begin
                    v_n[k] = 1'b0;
                    c_n[k] = CTRL_BUBBLE;
                end
            end
        end
        occ_n = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_n = occ_n + OCC_W'(v_n[k]);
        end
    end

    // Stage registers and occupancy; reset returns every stage to a NOP.
    always_ff @(posedge clk) begin
        // NOTE: every stage is reset (not just valid) because c must never
        // carry live write enables out of reset and PC must read PC_RST.
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= CTRL_BUBBLE;
                d_q[k] <= '0;
                p_q[k] <= PC_RST;
            end
            occ_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep the shift order-independent.
            for (int k = 0; k < DEPTH; k++) begin
                v_q[k] <= v_n[k];
                c_q[k] <= c_n[k];
                d_q[k] <= d_n[k];
                p_q[k] <= p_n[k];
            end
            occ_q <= occ_n;
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_ctrl  = c_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign out_pc    = p_q[DEPTH-1];
    assign occupancy = occ_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_stall_cnt_q;
    logic [31:0] perf_bubble_cnt_q;
    logic        stall_evt;
    logic        nop_evt;

    assign stall_evt = stall && !flush;
    assign nop_evt   = flush || (!stall && (bubble || !in_valid));

    // Saturating event counters for stall cycles and NOPs entering stage 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt_q  <= '0;
            perf_bubble_cnt_q <= '0;
        end else begin
            if (stall_evt && perf_stall_cnt_q != 32'hFFFFFFFF)
                perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
            if (nop_evt && perf_bubble_cnt_q != 32'hFFFFFFFF)
                perf_bubble_cnt_q <= perf_bubble_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt  = perf_stall_cnt_q;
    assign perf_bubble_cnt = perf_bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed-vector bench for pipe_stage_chain at DEPTH=2.
// Exercises perf counters when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_chain;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [15:0]  in_ctrl;
    logic [127:0] in_data;
    logic [31:0]  in_pc;
    logic         stall, bubble, flush;
    logic         out_valid;
    logic [15:0]  out_ctrl;
    logic [127:0] out_data;
    logic [31:0]  out_pc;
    logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  perf_stall_cnt, perf_bubble_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] BUB_DATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

    pipe_stage_chain #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
        .stall(stall), .bubble(bubble), .flush(flush),
        .out_valid(out_valid), .out_ctrl(out_ctrl), .out_data(out_data), .out_pc(out_pc),
`ifdef PIPE_STAGE_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; in_pc = '0;
        stall = 1'b0; bubble = 1'b0; flush = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_ctrl",  out_ctrl, 0);
        check("rst_pc",    out_pc, 32'h80000000);
        check("rst_occ",   occupancy, 0);

        // Stream 0x100, 0x104
        in_valid = 1'b1; in_ctrl = 16'h0011; in_data = 128'hA; in_pc = 32'h100;
        step();
        check("s1_occ",   occupancy, 1);
        check("s1_valid", out_valid, 0);
        in_pc = 32'h104;
        step();
        check("s2_pc",    out_pc, 32'h100);
        check("s2_valid", out_valid, 1);
        check("s2_ctrl",  out_ctrl, 16'h0011);
        check("s2_occ",   occupancy, 2);

        // Stall 3 cycles with 0x108 offered; bubble on one of them is ignored
        stall = 1'b1; in_pc = 32'h108;
        for (int i = 0; i < 3; i++) begin
            bubble = (i == 1);
            step();
            check("stall_pc",  out_pc, 32'h100);
            check("stall_occ", occupancy, 2);
        end
        stall = 1'b0; bubble = 1'b0;
        step();
        check("rel_pc",  out_pc, 32'h104);
        check("rel_occ", occupancy, 2);
        in_pc = 32'h10C;
        step();
        check("s3_pc", out_pc, 32'h108);

        // Bubble with live ctrl offered
        in_ctrl = 16'hFFFF; in_data = BUB_DATA; in_pc = 32'h200; bubble = 1'b1;
        step();
        check("bub_out_pc", out_pc, 32'h10C);
        check("bub_occ",    occupancy, 1);
        bubble = 1'b0; in_valid = 1'b0; in_data = 128'h5555; in_pc = 32'h204;
        step();
        check("bub_valid", out_valid, 0);
        check("bub_ctrl",  out_ctrl, 0);
        check("bub_data",  out_data, BUB_DATA);
        check("bub_pc",    out_pc, 32'h200);
        check("bub_occ0",  occupancy, 0);
        step();
        check("inv_ctrl",  out_ctrl, 0);
        check("inv_pc",    out_pc, 32'h204);
        check("inv_valid", out_valid, 0);

        // Fill, then flush + stall together
        in_valid = 1'b1; in_ctrl = 16'h0022; in_pc = 32'h300;
        step();
        in_pc = 32'h304;
        step();
        check("fill_occ", occupancy, 2);
        flush = 1'b1; stall = 1'b1; in_pc = 32'h308;
        step();
        check("fl_occ",   occupancy, 0);
        check("fl_valid", out_valid, 0);
        check("fl_ctrl",  out_ctrl, 0);
        check("fl_pc",    out_pc, 32'h304);
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_pc = 32'h30C;
        step();
        check("fl2_pc",    out_pc, 32'h308);
        check("fl2_valid", out_valid, 0);
        check("fl2_occ",   occupancy, 0);

        // Reset mid-operation discards in-flight work
        in_valid = 1'b1; in_pc = 32'h400;
        step();
        check("mid_occ1", occupancy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_occ",  occupancy, 0);
        check("mid_pc",   out_pc, 32'h80000000);
        check("mid_ctrl", out_ctrl, 0);

`ifdef PIPE_STAGE_PERF_EN
        in_valid = 1'b1; in_pc = 32'h500;
        step();
        check("perf_st0", perf_stall_cnt, 0);
        check("perf_bu0", perf_bubble_cnt, 0);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        stall = 1'b0; bubble = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bubble = 1'b0;
        check("perf_st5", perf_stall_cnt, 5);
        check("perf_bu3", perf_bubble_cnt, 3);
        force dut.perf_stall_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.perf_stall_cnt_q;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("perf_sat", perf_stall_cnt, 32'hFFFFFFFF);
        end
        stall = 1'b0;
        check("perf_bu_hold", perf_bubble_cnt, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
